// File: rtl/riscv_hazard_unit.sv
// Scoreboard-based stall/flush/bypass unit beside ID; stall and flush are combinational, bypass selects registered.
// No backpressure of its own; optional stall/flush perf counters under HAZARD_PERF_EN.
module riscv_hazard_unit #(
    parameter int STAGES   = 3,
    parameter int LOAD_LAT = 2,
    parameter int BR_STAGE = 1,
    parameter int CNT_W    = 32,
    parameter int SEL_W    = $clog2(STAGES)
) (
    input  logic             CLOCK_50,
    input  logic             rstn,
    input  logic             id_valid,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic [4:0]       id_rd,
    input  logic             id_wr,
    input  logic             id_load,
    input  logic             id_eof,
    input  logic             ex_branch_taken,
    output logic             stall,
    output logic             flush,
    output logic [SEL_W-1:0] fwd_a_sel,
    output logic [SEL_W-1:0] fwd_b_sel,
    output logic             done,
    output logic [CNT_W-1:0] cycle_count,
    output logic [CNT_W-1:0] instr_count,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    logic             r_sb_vld  [STAGES];
    logic [4:0]       r_sb_rd   [STAGES];
    logic             r_sb_wr   [STAGES];
    logic             r_sb_load [STAGES];

    logic [SEL_W-1:0] r_fwd_a;
    logic [SEL_W-1:0] r_fwd_b;
    logic             r_eof_seen;
    logic             r_done;
    logic [CNT_W-1:0] r_cycle_cnt;
    logic [CNT_W-1:0] r_instr_cnt;

    logic [SEL_W:0]   w_look_a;
    logic [SEL_W:0]   w_look_b;
    logic             w_stall;
    logic             w_flush;
    logic             w_issue;
    logic             w_empty;
    logic             w_done;

    // Returns {load_use_hazard, bypass_select}; the loop runs oldest to youngest so the youngest match wins.
    function automatic logic [SEL_W:0] f_lookup(input logic [4:0] src, input logic use_src);
        logic [SEL_W:0] res;
        res = '0;
        for (int k = STAGES - 1; k >= 0; k--) begin
            if (r_sb_vld[k] && r_sb_wr[k] && (r_sb_rd[k] == src) && (src != 5'd0) && use_src) begin
                if (k == STAGES - 1)
                    res = '0;
                else
                    res = {(r_sb_load[k] && ((k + 1) < LOAD_LAT)), SEL_W'(k + 1)};
            end
        end
        return res;
    endfunction

    always_comb begin
        w_look_a = f_lookup(id_rs1, id_use_rs1);
        w_look_b = f_lookup(id_rs2, id_use_rs2);
    end

    always_comb begin
        w_empty = 1'b1;
        for (int k = 0; k < STAGES; k++) begin
            if (r_sb_vld[k])
                w_empty = 1'b0;
        end
    end

    assign w_flush = ex_branch_taken;
    assign w_stall = !w_flush && (w_look_a[SEL_W] || w_look_b[SEL_W]);
    assign w_issue = id_valid && !w_stall && !w_flush;
    assign w_done  = r_done || (r_eof_seen && w_empty);

    // EOF never enters the scoreboard so it cannot delay the drain.
    always_ff @(posedge CLOCK_50 or negedge rstn) begin
        if (!rstn) begin
            for (int k = 0; k < STAGES; k++) begin
                r_sb_vld[k]  <= 1'b0;
                r_sb_rd[k]   <= 5'd0;
                r_sb_wr[k]   <= 1'b0;
                r_sb_load[k] <= 1'b0;
            end
        end else begin
            r_sb_vld[0]  <= w_issue && !id_eof;
            r_sb_rd[0]   <= id_rd;
            r_sb_wr[0]   <= id_wr && !id_eof;
            r_sb_load[0] <= id_load && !id_eof;
            for (int k = 1; k < STAGES; k++) begin
                if (w_flush && ((k - 1) < BR_STAGE))
                    r_sb_vld[k] <= 1'b0;
                else
                    r_sb_vld[k] <= r_sb_vld[k-1];
                r_sb_rd[k]   <= r_sb_rd[k-1];
                r_sb_wr[k]   <= r_sb_wr[k-1];
                r_sb_load[k] <= r_sb_load[k-1];
            end
        end
    end

    always_ff @(posedge CLOCK_50 or negedge rstn) begin
        if (!rstn) begin
            r_fwd_a <= '0;
            r_fwd_b <= '0;
        end else if (w_stall || w_flush) begin
            r_fwd_a <= '0;
            r_fwd_b <= '0;
        end else begin
            r_fwd_a <= w_look_a[SEL_W-1:0];
            r_fwd_b <= w_look_b[SEL_W-1:0];
        end
    end

    always_ff @(posedge CLOCK_50 or negedge rstn) begin
        if (!rstn) begin
            r_eof_seen  <= 1'b0;
            r_done      <= 1'b0;
            r_cycle_cnt <= '0;
            r_instr_cnt <= '0;
        end else begin
            if (w_issue && id_eof)
                r_eof_seen <= 1'b1;
            r_done <= w_done;
            if (!w_done) begin
                r_cycle_cnt <= r_cycle_cnt + CNT_W'(1);
                if (w_issue)
                    r_instr_cnt <= r_instr_cnt + CNT_W'(1);
            end
        end
    end

`ifdef HAZARD_PERF_EN
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    always_ff @(posedge CLOCK_50 or negedge rstn) begin
        if (!rstn) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else if (!w_done) begin
            if (w_stall)
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            if (w_flush)
                r_flush_cnt <= r_flush_cnt + CNT_W'(1);
        end
    end

    assign stall_count = r_stall_cnt;
    assign flush_count = r_flush_cnt;
`else
    assign stall_count = '0;
    assign flush_count = '0;
`endif

    assign stall       = w_stall;
    assign flush       = w_flush;
    assign fwd_a_sel   = r_fwd_a;
    assign fwd_b_sel   = r_fwd_b;
    assign done        = w_done;
    assign cycle_count = r_cycle_cnt;
    assign instr_count = r_instr_cnt;

endmodule

// File: tb/tb_riscv_hazard_unit.sv
// Random and directed stimulus for riscv_hazard_unit against an issue-history reference model.
module tb_riscv_hazard_unit;
    localparam int STAGES   = 3;
    localparam int LOAD_LAT = 2;
    localparam int BR_STAGE = 1;
    localparam int CNT_W    = 32;
    localparam int SEL_W    = $clog2(STAGES);
    localparam int RING     = 32;

    logic             CLOCK_50;
    logic             rstn;
    logic             id_valid, id_use_rs1, id_use_rs2, id_wr, id_load, id_eof, ex_branch_taken;
    logic [4:0]       id_rs1, id_rs2, id_rd;
    logic             stall, flush, done;
    logic [SEL_W-1:0] fwd_a_sel, fwd_b_sel;
    logic [CNT_W-1:0] cycle_count, instr_count, stall_count, flush_count;

    riscv_hazard_unit #(
        .STAGES(STAGES), .LOAD_LAT(LOAD_LAT), .BR_STAGE(BR_STAGE), .CNT_W(CNT_W)
    ) dut (
        .CLOCK_50(CLOCK_50), .rstn(rstn), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd), .id_wr(id_wr),
        .id_load(id_load), .id_eof(id_eof), .ex_branch_taken(ex_branch_taken),
        .stall(stall), .flush(flush), .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel), .done(done),
        .cycle_count(cycle_count), .instr_count(instr_count), .stall_count(stall_count),
        .flush_count(flush_count)
    );

    initial CLOCK_50 = 1'b0;
    always #5 CLOCK_50 = ~CLOCK_50;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    // Reference model: what was issued in each absolute cycle; age k = now-1-c.
    logic       m_v  [RING];
    logic [4:0] m_rd [RING];
    logic       m_wr [RING];
    logic       m_ld [RING];
    int         m_now;
    logic       m_eof, m_done_r;
    int         m_sa, m_sb;
    longint     m_cyc, m_ins, m_stc, m_flc;

    logic             s_stall, s_flush, s_done;
    int               s_fa, s_fb;
    logic [CNT_W-1:0] s_cyc, s_ins, s_stc, s_flc;

    function automatic void m_lookup(input logic [4:0] s, input logic u, output logic haz, output int sel);
        haz = 1'b0;
        sel = 0;
        if (u && s != 5'd0) begin
            for (int k = 0; k < STAGES; k++) begin
                int i;
                i = (m_now - 1 - k) % RING;
                if (m_v[i] && m_wr[i] && m_rd[i] == s) begin
                    if (k < STAGES - 1) begin
                        sel = k + 1;
                        haz = m_ld[i] && (k + 1 < LOAD_LAT);
                    end
                    break;
                end
            end
        end
    endfunction

    function automatic logic m_empty();
        for (int k = 0; k < STAGES; k++)
            if (m_v[(m_now - 1 - k) % RING]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < RING; i++) m_v[i] = 1'b0;
        m_now = RING; m_eof = 1'b0; m_done_r = 1'b0;
        m_sa = 0; m_sb = 0; m_cyc = 0; m_ins = 0; m_stc = 0; m_flc = 0;
    endtask

    task automatic model_check_advance();
        logic ha, hb, mst, mfl, mdn, iss;
        int   sa, sb, idx;
        m_lookup(id_rs1, id_use_rs1, ha, sa);
        m_lookup(id_rs2, id_use_rs2, hb, sb);
        mfl = ex_branch_taken;
        mst = !mfl && (ha || hb);
        mdn = m_done_r || (m_eof && m_empty());
        s_stall = stall; s_flush = flush; s_done = done; s_fa = int'(fwd_a_sel); s_fb = int'(fwd_b_sel);
        s_cyc = cycle_count; s_ins = instr_count; s_stc = stall_count; s_flc = flush_count;
        chk("stall", stall, mst);
        chk("flush", flush, mfl);
        chk("fwd_a", fwd_a_sel, m_sa);
        chk("fwd_b", fwd_b_sel, m_sb);
        chk("done", done, mdn);
        chk("cycle_count", cycle_count, m_cyc % (64'd1 << CNT_W));
        chk("instr_count", instr_count, m_ins % (64'd1 << CNT_W));
`ifdef HAZARD_PERF_EN
        chk("stall_count", stall_count, m_stc % (64'd1 << CNT_W));
        chk("flush_count", flush_count, m_flc % (64'd1 << CNT_W));
`else
        chk("stall_count", stall_count, 0);
        chk("flush_count", flush_count, 0);
`endif
        iss = id_valid && !mst && !mfl;
        if (!mdn) begin
            m_cyc++;
            if (iss) m_ins++;
            if (mst) m_stc++;
            if (mfl) m_flc++;
        end
        m_sa = (mst || mfl) ? 0 : sa;
        m_sb = (mst || mfl) ? 0 : sb;
        if (mfl)
            for (int k = 0; k < BR_STAGE; k++) m_v[(m_now - 1 - k) % RING] = 1'b0;
        idx = m_now % RING;
        m_v[idx] = iss && !id_eof; m_rd[idx] = id_rd; m_wr[idx] = id_wr; m_ld[idx] = id_load;
        if (iss && id_eof) m_eof = 1'b1;
        m_done_r = mdn;
        m_now++;
    endtask

    task automatic step();
        @(negedge CLOCK_50);
        model_check_advance();
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic set_op(input logic v, input logic [4:0] r1, input logic u1, input logic [4:0] r2,
                          input logic u2, input logic [4:0] rd, input logic wr, input logic ld,
                          input logic eof, input logic br);
        id_valid = v; id_rs1 = r1; id_use_rs1 = u1; id_rs2 = r2; id_use_rs2 = u2;
        id_rd = rd; id_wr = wr; id_load = ld; id_eof = eof; ex_branch_taken = br;
    endtask

    task automatic idle();
        set_op(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Asynchronous assertion mid-cycle; outputs must clear without a clock edge.
    task automatic do_reset();
        rstn = 1'b0;
        #1;
        chk("rst_stall", stall, 0);
        chk("rst_flush", flush, ex_branch_taken);
        chk("rst_fwd_a", fwd_a_sel, 0);
        chk("rst_fwd_b", fwd_b_sel, 0);
        chk("rst_done", done, 0);
        chk("rst_cycle", cycle_count, 0);
        chk("rst_instr", instr_count, 0);
        chk("rst_stallc", stall_count, 0);
        chk("rst_flushc", flush_count, 0);
        model_reset();
        @(posedge CLOCK_50);
        #1;
        rstn = 1'b1;
    endtask

    task automatic rand_op();
        set_op($urandom_range(3, 0) != 0, 5'($urandom_range(3, 0)), $urandom_range(3, 0) != 0,
               5'($urandom_range(3, 0)), $urandom_range(3, 0) != 0, 5'($urandom_range(3, 0)),
               $urandom_range(3, 0) != 0, $urandom_range(2, 0) == 0, $urandom_range(63, 0) == 0,
               $urandom_range(7, 0) == 0);
    endtask

    initial begin
        logic [CNT_W-1:0] held;
        int               wait_n;
        rstn = 1'b1;
        idle();
        #2;
        do_reset();

        // load-use: lw x3; add x4,x3,x0
        set_op(1, 0, 0, 0, 0, 3, 1, 1, 0, 0); step();
        set_op(1, 3, 1, 0, 1, 4, 1, 0, 0, 0); step();
        chk("lu_stall", s_stall, 1);
        step();
        chk("lu_release", s_stall, 0);
        idle(); step();
        chk("lu_fwd_a", s_fa, 2);
`ifdef HAZARD_PERF_EN
        chk("lu_stall_cnt", s_stc, 1);
`endif

        // back-to-back ALU dependency
        set_op(1, 0, 0, 0, 0, 5, 1, 0, 0, 0); step();
        set_op(1, 5, 1, 5, 1, 6, 1, 0, 0, 0); step();
        chk("b2b_stall", s_stall, 0);
        idle(); step();
        chk("b2b_fwd_a", s_fa, 1);
        chk("b2b_fwd_b", s_fb, 1);

        // distance-2 dependency
        set_op(1, 0, 0, 0, 0, 5, 1, 0, 0, 0); step();
        idle(); step();
        set_op(1, 5, 1, 1, 1, 7, 1, 0, 0, 0); step();
        chk("d2_stall", s_stall, 0);
        idle(); step();
        chk("d2_fwd_a", s_fa, 2);
        chk("d2_fwd_b", s_fb, 0);

        // x0 destination and unused source
        set_op(1, 0, 0, 0, 0, 0, 1, 1, 0, 0); step();
        set_op(1, 0, 1, 0, 1, 1, 1, 0, 0, 0); step();
        chk("x0_stall", s_stall, 0);
        set_op(1, 0, 0, 0, 0, 5, 1, 0, 0, 0); step();
        chk("x0_fwd_a", s_fa, 0);
        set_op(1, 0, 1, 5, 0, 8, 1, 0, 0, 0); step();
        idle(); step();
        chk("nouse_fwd_b", s_fb, 0);

        // branch taken in the same cycle as a load-use
        do_reset();
        set_op(1, 0, 0, 0, 0, 3, 1, 1, 0, 0); step();
        set_op(1, 3, 1, 0, 0, 4, 1, 0, 0, 1); step();
        chk("fl_stall", s_stall, 0);
        chk("fl_flush", s_flush, 1);
        held = s_ins;
        set_op(1, 3, 1, 0, 0, 4, 1, 0, 0, 0); step();
        chk("fl_instr_hold", s_ins, held);
        chk("fl_killed_no_stall", s_stall, 0);
`ifdef HAZARD_PERF_EN
        chk("fl_flush_cnt", s_flc, 1);
`endif

        // EOF drain: three instructions then EOF
        do_reset();
        for (int i = 0; i < 3; i++) begin
            set_op(1, 0, 0, 0, 0, 5'(10 + i), 1, 0, 0, 0); step();
        end
        set_op(1, 0, 0, 0, 0, 0, 0, 0, 1, 0); step();
        idle();
        wait_n = 0;
        for (int i = 1; i <= 20; i++) begin
            step();
            if (s_done) begin wait_n = i; break; end
        end
        chk("eof_drain_cycles", wait_n, STAGES);
        held = s_cyc;
        set_op(1, 0, 0, 0, 0, 9, 1, 0, 0, 0); step(); step(); step();
        chk("frozen_cycle", s_cyc, held);
        chk("done_sticky", s_done, 1);

        // randomized run with periodic asynchronous resets
        do_reset();
        for (int it = 0; it < 1500; it++) begin
            if (it % 300 == 299) do_reset();
            rand_op();
            step();
        end

        do_reset();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/riscv_hazard_unit.md
Name: riscv_hazard_unit

Overview:
- Parametrised hazard, forwarding and pipeline-bookkeeping unit for the pipelined RISC-V core.
- Tracks in-flight destination registers in a shift-register scoreboard of configurable depth and issues stall and flush.
- Produces registered bypass selects for the EX operand muxes.
- Maintains cycle, instruction, stall and flush counters and a drain-aware done flag.
- Sits beside the ID stage and replaces the core's fixed, hand-written stall/bypass equations.

Parameters:
- STAGES, 3, scoreboard entries after ID (entry 0 = ID/EX, 1 = EX/MEM, 2 = MEM/WB, ...); legal range 2..8.
- LOAD_LAT, 2, lowest entry index from which a load result can be forwarded; range 1..STAGES-1.
- BR_STAGE, 1, entry index holding a branch when ex_branch_taken is asserted; range 0..STAGES-1.
- CNT_W, 32, width of every performance counter.
- SEL_W, $clog2(STAGES), width of the fwd_*_sel outputs.

Ports:
- CLOCK_50, in, 1, clock, rising edge.
- rstn, in, 1, asynchronous active-low reset.
- id_valid, in, 1, a real instruction is present in ID.
- id_rs1, in, 5, source register 1 of the ID instruction.
- id_rs2, in, 5, source register 2 of the ID instruction.
- id_use_rs1, in, 1, the ID instruction reads rs1.
- id_use_rs2, in, 1, the ID instruction reads rs2.
- id_rd, in, 5, destination register of the ID instruction.
- id_wr, in, 1, the ID instruction writes rd.
- id_load, in, 1, the ID instruction is LW.
- id_eof, in, 1, the ID instruction is the EOF word 32'hFFFF_FFFF.
- ex_branch_taken, in, 1, branch at entry BR_STAGE is resolved taken.
- stall, out, 1, hold PC and IF/ID this cycle (combinational).
- flush, out, 1, kill younger instructions (combinational; equals ex_branch_taken).
- fwd_a_sel, out, SEL_W, registered operand-A source for the instruction now in EX.
- fwd_b_sel, out, SEL_W, registered operand-B source for the instruction now in EX.
- done, out, 1, EOF issued and pipeline drained (sticky).
- cycle_count, out, CNT_W, clock cycles since reset.
- instr_count, out, CNT_W, instructions issued from ID.
- stall_count, out, CNT_W, cycles with stall=1.
- flush_count, out, CNT_W, cycles with flush=1.

Behaviour:
- Scoreboard entry fields: {valid, rd, wr, load}.
- Every cycle, entry k+1 takes entry k. Entry 0 takes the ID instruction when id_valid & !stall & !flush; otherwise entry 0 takes a bubble (valid=0).
- Match at entry k for source s: valid & wr & rd==s & s!=0 & id_use_s. Only the youngest (lowest k) match is considered.
- Match at entry STAGES-1: the register file writes through, so select 0 and no hazard.
- Load-use: the youngest match is a load at entry k with k+1 < LOAD_LAT -> stall=1.
- Forward select: captured on !stall, giving fwd_x_sel = k+1 for the youngest match with k <= STAGES-2, else 0 (register file). When stall=1 or flush=1 the selects load 0.
- Flush: when ex_branch_taken=1, entries 0..BR_STAGE-1 are invalidated and the ID instruction is not issued. Flush has priority over stall; stall is forced to 0 during flush.
- Counters:
  - cycle_count increments every cycle until done.
  - instr_count increments on each issue.
  - All counters freeze once done=1 and wrap modulo 2^CNT_W.
- EOF: an issued id_eof sets an internal eof_seen flag. done rises the first cycle eof_seen=1 and all entries are invalid, then stays at 1 until reset. EOF is never inserted into the scoreboard (wr=0).
- Reset (asynchronous, any time including mid-stall or mid-flush): all entries invalid; stall/flush outputs follow their inputs with empty scoreboard; fwd_*_sel=0; done=0; eof_seen=0; all counters 0.
- stall and flush are combinational from the current scoreboard and inputs. No output depends on itself combinationally.

Optional Feature:
- Macro: HAZARD_PERF_EN.
- Defined: stall_count and flush_count are live counters, incremented on stall=1 and flush=1 cycles respectively, and frozen at done.
- Undefined: both outputs are tied to 0, their registers are not built, and cycle_count/instr_count are unaffected.

Test Plan:
- Back-to-back ALU dependency: issue add x5 (wr), then add x6,x5,x5 next cycle -> no stall; one cycle later fwd_a_sel=fwd_b_sel=1.
- Distance-2 dependency: add x5, then nop, then sub x7,x5,x1 -> fwd_a_sel=2, fwd_b_sel=0, stall never asserted.
- Load-use with LOAD_LAT=2: lw x3, then add x4,x3,x0 -> stall=1 for exactly one cycle, stall_count=1, then fwd_a_sel=2.
- x0 and no-use: lw x0 followed by add x1,x0,x0, and add with id_use_rs2=0 on a match -> no stall, selects 0.
- Branch flush while stalled: raise ex_branch_taken in the same cycle as a load-use -> stall=0, flush=1, entry 0 invalidated, instr_count unchanged that cycle, flush_count=1.
- EOF drain: issue 3 instructions then id_eof -> done rises exactly STAGES cycles after EOF issue, counters then freeze; deassert rstn mid-run -> all outputs 0 immediately.
